regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
Parametrised general-purpose register file for the pipelined MIPS core: 2 combinational read ports, 1 write port, write-through bypass, hardwired-zero register 0. Adds a per-register pending-write scoreboard (saturating counters) that flags read-after-write hazards and drives the decode-stage stall. Exposes a configurable window of registers for board display/debug, plus a sticky scoreboard-error flag.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
CNT_W, 2, pending-counter width per register; max outstanding writes = 2**CNT_W-1
DBG_BASE, 20, index of first register in debug window
DBG_COUNT, 4, number of registers in debug window (DBG_BASE+DBG_COUNT <= depth)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
rs_addr  in  ADDR_W  read port A address
rt_addr  in  ADDR_W  read port B address
rs_use  in  1  decode stage actually consumes rs this cycle
rt_use  in  1  decode stage actually consumes rt this cycle
rs_data  out  DATA_W  read port A data (combinational)
rt_data  out  DATA_W  read port B data (combinational)
we  in  1  write-back enable
wr_addr  in  ADDR_W  write-back address
wr_data  in  DATA_W  write-back data
issue_valid  in  1  an instruction with a destination register leaves decode this cycle
issue_addr  in  ADDR_W  its destination register
rs_busy  out  1  rs has an outstanding write not resolved this cycle
rt_busy  out  1  rt likewise
stall  out  1  (rs_use & rs_busy) | (rt_use & rt_busy)
sb_err  out  1  sticky scoreboard overflow/underflow flag
dbg_regs  out  DBG_COUNT*DATA_W  {R[DBG_BASE], R[DBG_BASE+1], ...}, R[DBG_BASE] in MSBs

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, all pending counters 0, sb_err 0. Outputs therefore read 0, busy/stall 0, dbg_regs 0. Reset mid-operation discards all in-flight reservations.
- Register 0: reads always 0; writes ignored; issue to 0 ignored (counter stays 0); never busy; never causes sb_err.
- Write: on rising edge with we=1 and wr_addr!=0, R[wr_addr] <= wr_data.
- Read/bypass: rs_data = wr_data when we & wr_addr==rs_addr & rs_addr!=0; else R[rs_addr]. Same for rt. Zero-latency: a value written in cycle N is visible combinationally in cycle N.
- Scoreboard counter cnt[r] per register, updated per edge:
  - issue only (issue_addr=r): cnt+1; if cnt already max -> cnt unchanged, sb_err<=1.
  - write only (wr_addr=r): cnt-1; if cnt already 0 -> cnt unchanged, sb_err<=1 (write without reservation).
  - issue and write to same r in same cycle: cnt unchanged, no error, even at 0 or max.
  - issue and write to different registers: both applied independently.
- Busy: rs_busy = cnt[rs_addr]!=0 minus bypass credit: if we & wr_addr==rs_addr and cnt[rs_addr]==1, rs_busy=0 (last outstanding write completes now and is bypassed). rs_addr=0 -> 0. Same for rt. Same-cycle issue does not affect busy in that cycle.
- stall purely combinational from busy and use inputs; the block does not gate issue_valid itself, upstream must not assert issue_valid while stall=1.
- sb_err: set as above, cleared only by reset.
- dbg_regs: combinational from storage (no bypass).

Test Plan:
- Reset: load R5=0x1234 then pulse rst=0 asynchronously mid-cycle -> rs_data for addr 5 reads 0 immediately, sb_err=0, stall=0.
- Zero reg: we=1, wr_addr=0, wr_data=0xFFFFFFFF; issue_addr=0 -> rs_data(0)=0, rs_busy=0, sb_err stays 0.
- Bypass: cycle N write R7=0xDEADBEEF with rs_addr=rt_addr=7 -> rs_data=rt_data=0xDEADBEEF same cycle; cycle N+1 with we=0 still 0xDEADBEEF.
- Hazard: issue R9 at cycle 0, rs_addr=9, rs_use=1 -> stall=1 cycles 1..k-1; write R9=0x55 at cycle k -> stall=0 and rs_data=0x55 in cycle k; rs_use=0 -> stall=0 regardless.
- Counter: issue R3 three times -> cnt=3, fourth issue -> sb_err=1, cnt=3; three writes -> busy drops combinationally on third; fifth write to R3 -> sb_err remains 1.
- Simultaneous: issue R4 and write R4 same cycle with cnt=0 -> cnt 0, no sb_err, R4 updated; dbg_regs with R20..R23=1,2,3,4 -> dbg_regs=0x00000001_00000002_00000003_00000004.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// ============================================================================
// regfile_scoreboard_if : decode/write-back/issue bundle for the register file
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface regfile_scoreboard_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DBG_COUNT = 4
);
  logic [ADDR_W-1:0]           rs_addr;
  logic [ADDR_W-1:0]           rt_addr;
  logic                        rs_use;
  logic                        rt_use;
  logic [DATA_W-1:0]           rs_data;
  logic [DATA_W-1:0]           rt_data;
  logic                        we;
  logic [ADDR_W-1:0]           wr_addr;
  logic [DATA_W-1:0]           wr_data;
  logic                        issue_valid;
  logic [ADDR_W-1:0]           issue_addr;
  logic                        rs_busy;
  logic                        rt_busy;
  logic                        stall;
  logic                        sb_err;
  logic [DBG_COUNT*DATA_W-1:0] dbg_regs;

  modport master (
    output rs_addr, rt_addr, rs_use, rt_use,
    output we, wr_addr, wr_data, issue_valid, issue_addr,
    input  rs_data, rt_data, rs_busy, rt_busy, stall, sb_err, dbg_regs
  );

  modport slave (
    input  rs_addr, rt_addr, rs_use, rt_use,
    input  we, wr_addr, wr_data, issue_valid, issue_addr,
    output rs_data, rt_data, rs_busy, rt_busy, stall, sb_err, dbg_regs
  );
endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : 2R/1W register file with write-through bypass and a
//                      per-register pending-write scoreboard driving stall
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 2,
  parameter int DBG_BASE  = 20,
  parameter int DBG_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_scoreboard_if.slave   bus
);

  localparam int              c_depth   = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs_q [c_depth];
  logic [DATA_W-1:0] regs_d [c_depth];
  logic [CNT_W-1:0]  cnt_q  [c_depth];
  logic [CNT_W-1:0]  cnt_d  [c_depth];
  logic              sb_err_q;
  logic              sb_err_d;

  logic [c_depth-1:0] issue_hit;
  logic [c_depth-1:0] wr_hit;
  logic               rs_wr_hit;
  logic               rt_wr_hit;
  logic [CNT_W-1:0]   rs_cnt;
  logic [CNT_W-1:0]   rt_cnt;

  // One-hot decode of issue/write targets; bit 0 masked so R0 never counts.
  assign issue_hit = bus.issue_valid ? ((c_depth'(1) << bus.issue_addr) & ~c_depth'(1))
                                     : '0;
  assign wr_hit    = bus.we ? ((c_depth'(1) << bus.wr_addr) & ~c_depth'(1)) : '0;

  always_comb begin
    regs_d = regs_q;
    if (bus.we && (bus.wr_addr != '0)) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
  end

  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < c_depth; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue_hit[r] && !wr_hit[r]) begin
        if (cnt_q[r] == c_cnt_max) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end
      end else if (wr_hit[r] && !issue_hit[r]) begin
        if (cnt_q[r] == '0) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < c_depth; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < c_depth; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
      sb_err_q <= sb_err_d;
    end
  end

  assign rs_wr_hit = bus.we && (bus.wr_addr == bus.rs_addr) && (bus.rs_addr != '0);
  assign rt_wr_hit = bus.we && (bus.wr_addr == bus.rt_addr) && (bus.rt_addr != '0);

  assign bus.rs_data = rs_wr_hit ? bus.wr_data : regs_q[bus.rs_addr];
  assign bus.rt_data = rt_wr_hit ? bus.wr_data : regs_q[bus.rt_addr];

  assign rs_cnt = cnt_q[bus.rs_addr];
  assign rt_cnt = cnt_q[bus.rt_addr];

  // A write landing now on the last outstanding reservation is bypassed, so not busy.
  assign bus.rs_busy = (bus.rs_addr != '0) && (rs_cnt != '0)
                       && !(rs_wr_hit && (rs_cnt == CNT_W'(1)));
  assign bus.rt_busy = (bus.rt_addr != '0) && (rt_cnt != '0)
                       && !(rt_wr_hit && (rt_cnt == CNT_W'(1)));

  assign bus.stall  = (bus.rs_use && bus.rs_busy) || (bus.rt_use && bus.rt_busy);
  assign bus.sb_err = sb_err_q;

  always_comb begin
    bus.dbg_regs = '0;
    for (int i = 0; i < DBG_COUNT; i++) begin
      bus.dbg_regs[(DBG_COUNT-1-i)*DATA_W +: DATA_W] = regs_q[DBG_BASE+i];
    end
  end

endmodule

`default_nettype wire
